// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman game logic.
//   phase_t        : encoding of the frame scheduler phases, also driven on
//                    the scheduler's phase output for status/debug.
//   FRAME_DIV_60HZ : clk cycles per frame at 100 MHz / 60 Hz, so every block
//                    that derives a frame rate agrees on it.
package pacman_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_INPUT   = 3'd1,
        PH_PAC     = 3'd2,
        PH_GHOST   = 3'd3,
        PH_COLLIDE = 3'd4
    } phase_t;

    localparam int FRAME_DIV_60HZ = 1_666_667;

endpackage

// File: rtl/frame_divider.sv
// Free-running frame divider.
// Counts 0..TICK_DIV-1 forever and raises frame_tick for the single cycle in
// which the count sits at TICK_DIV-1; the count then wraps to 0.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low
//   frame_tick out  one-cycle pulse per frame
module frame_divider
    import pacman_pkg::*;
#(
    parameter int TICK_DIV = FRAME_DIV_60HZ
) (
    input  logic clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Frame-level sequencer for the Pacman game logic.
// Each accepted frame runs INPUT -> PAC -> GHOST (one slot per ghost, only on
// ghost frames) -> COLLIDE -> IDLE.
//
// Handshake with each subsystem: the scheduler raises *_start for exactly the
// first cycle of a phase (for ghosts, of each ghost slot). The subsystem
// answers with a one-cycle *_done on any later cycle of that phase; a done in
// the start cycle itself, or outside its own phase, is ignored. If no done
// comes within WDOG cycles the watchdog flags wdog_err and the phase advances
// as if the done had arrived.
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   run                      1 = accept frames, 0 = paused (divider runs on)
//   frame_tick               frame strobe from the divider
//   in_start/in_done         input sampler handshake
//   pac_start/pac_done       Pacman mover handshake
//   ghost_start/ghost_done   ghost mover handshake, ghost_id = slot served
//   col_start/col_done       collision checker handshake
//   phase                    current phase (phase_t encoding), busy = !IDLE
//   overrun, overrun_cnt     sticky dropped-frame flag, saturating count
//   wdog_err                 sticky phase-timeout flag
//   clear_err                synchronous clear of the three error outputs
module frame_scheduler
    import pacman_pkg::*;
#(
    parameter int TICK_DIV   = FRAME_DIV_60HZ,
    parameter int NUM_GHOSTS = 4,
    parameter int GHOST_DIV  = 2,
    parameter int WDOG       = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       frame_tick,
    output logic       in_start,
    input  logic       in_done,
    output logic       pac_start,
    input  logic       pac_done,
    output logic       ghost_start,
    output logic [2:0] ghost_id,
    input  logic       ghost_done,
    output logic       col_start,
    input  logic       col_done,
    output logic [2:0] phase,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] overrun_cnt,
    output logic       wdog_err,
    input  logic       clear_err
);

    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(WDOG - 1);
    localparam logic [2:0]      LAST_GHOST = 3'(NUM_GHOSTS - 1);
    localparam logic [3:0]      GDIV_LAST  = 4'(GHOST_DIV - 1);

    phase_t          state;
    logic [WD_W-1:0] wd;
    logic [3:0]      gframe;
    logic            start_now;
    logic            done_sel;
    logic            timeout;
    logic            advance;
    logic            drop;

    frame_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick)
    );

    // Only the start of the current phase can be high, so OR-ing them marks
    // the first cycle of a phase or ghost slot.
    assign start_now = in_start | pac_start | ghost_start | col_start;

    always_comb begin
        done_sel = 1'b0;
        case (state)
            PH_INPUT:   done_sel = in_done;
            PH_PAC:     done_sel = pac_done;
            PH_GHOST:   done_sel = ghost_done;
            PH_COLLIDE: done_sel = col_done;
            default:    done_sel = 1'b0;
        endcase
    end

    // The watchdog reaches WDOG on the edge where it currently reads WDOG-1.
    assign timeout = (state != PH_IDLE) && (wd == WD_LAST);
    assign advance = (state != PH_IDLE) && ((done_sel && !start_now) || timeout);
    assign drop    = frame_tick && (state != PH_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= PH_IDLE;
            busy        <= 1'b0;
            in_start    <= 1'b0;
            pac_start   <= 1'b0;
            ghost_start <= 1'b0;
            col_start   <= 1'b0;
            ghost_id    <= '0;
            gframe      <= '0;
            wd          <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            wdog_err    <= 1'b0;
        end else begin
            in_start    <= 1'b0;
            pac_start   <= 1'b0;
            ghost_start <= 1'b0;
            col_start   <= 1'b0;

            case (state)
                PH_IDLE: begin
                    if (frame_tick && run) begin
                        state    <= PH_INPUT;
                        busy     <= 1'b1;
                        in_start <= 1'b1;
                    end
                end
                PH_INPUT: begin
                    if (advance) begin
                        state     <= PH_PAC;
                        pac_start <= 1'b1;
                    end
                end
                PH_PAC: begin
                    if (advance) begin
                        // The ghost frame counter steps once per frame here,
                        // after this frame's ghost decision has used it.
                        gframe <= (gframe == GDIV_LAST) ? 4'd0 : gframe + 4'd1;
                        if (gframe == 4'd0) begin
                            state       <= PH_GHOST;
                            ghost_start <= 1'b1;
                        end else begin
                            state     <= PH_COLLIDE;
                            col_start <= 1'b1;
                        end
                    end
                end
                PH_GHOST: begin
                    if (advance) begin
                        if (ghost_id < LAST_GHOST) begin
                            ghost_id    <= ghost_id + 3'd1;
                            ghost_start <= 1'b1;
                        end else begin
                            ghost_id  <= '0;
                            state     <= PH_COLLIDE;
                            col_start <= 1'b1;
                        end
                    end
                end
                PH_COLLIDE: begin
                    if (advance) begin
                        state <= PH_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= PH_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Restart on every phase/slot entry, count while waiting.
            if (state == PH_IDLE || advance) begin
                wd <= '0;
            end else begin
                wd <= wd + 1'b1;
            end

            // Error flags: a new event in the same cycle as clear_err wins.
            if (timeout) begin
                wdog_err <= 1'b1;
            end else if (clear_err) begin
                wdog_err <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
                if (clear_err) begin
                    overrun_cnt <= 8'd1;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (clear_err) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: TICK_DIV 20, 4 ghosts, GHOST_DIV 2, WDOG 1023
    logic       run_a, clear_a;
    logic       frame_tick_a, in_start_a, pac_start_a, ghost_start_a, col_start_a;
    logic       busy_a, overrun_a, wdog_err_a;
    logic [2:0] ghost_id_a, phase_a;
    logic [7:0] overrun_cnt_a;
    logic [3:0] auto_a = '0, en_a, man_a;
    wire  [3:0] dn_a = (auto_a & en_a) | man_a;
    wire  [3:0] st_a = {col_start_a, ghost_start_a, pac_start_a, in_start_a};

    frame_scheduler #(.TICK_DIV(20), .NUM_GHOSTS(4), .GHOST_DIV(2), .WDOG(1023)) dut_a (
        .clk(clk), .reset(reset), .run(run_a), .frame_tick(frame_tick_a),
        .in_start(in_start_a), .in_done(dn_a[0]),
        .pac_start(pac_start_a), .pac_done(dn_a[1]),
        .ghost_start(ghost_start_a), .ghost_id(ghost_id_a), .ghost_done(dn_a[2]),
        .col_start(col_start_a), .col_done(dn_a[3]),
        .phase(phase_a), .busy(busy_a), .overrun(overrun_a),
        .overrun_cnt(overrun_cnt_a), .wdog_err(wdog_err_a), .clear_err(clear_a)
    );

    // ---------------- DUT B: TICK_DIV 20, 4 ghosts, GHOST_DIV 1, WDOG 10
    logic       run_b, clear_b;
    logic       frame_tick_b, in_start_b, pac_start_b, ghost_start_b, col_start_b;
    logic       busy_b, overrun_b, wdog_err_b;
    logic [2:0] ghost_id_b, phase_b;
    logic [7:0] overrun_cnt_b;
    logic [3:0] auto_b = '0, en_b, man_b;
    wire  [3:0] dn_b = (auto_b & en_b) | man_b;
    wire  [3:0] st_b = {col_start_b, ghost_start_b, pac_start_b, in_start_b};

    frame_scheduler #(.TICK_DIV(20), .NUM_GHOSTS(4), .GHOST_DIV(1), .WDOG(10)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .frame_tick(frame_tick_b),
        .in_start(in_start_b), .in_done(dn_b[0]),
        .pac_start(pac_start_b), .pac_done(dn_b[1]),
        .ghost_start(ghost_start_b), .ghost_id(ghost_id_b), .ghost_done(dn_b[2]),
        .col_start(col_start_b), .col_done(dn_b[3]),
        .phase(phase_b), .busy(busy_b), .overrun(overrun_b),
        .overrun_cnt(overrun_cnt_b), .wdog_err(wdog_err_b), .clear_err(clear_b)
    );

    // ---------------- subsystem responders ----------------
    // Each enabled subsystem answers its start with a one-cycle done in the
    // following cycle (earliest cycle the scheduler accepts it).
    int pend_a [4];
    int pend_b [4];
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            auto_a[p] = 1'b0;
            if (pend_a[p] > 0) begin
                pend_a[p] = pend_a[p] - 1;
                if (pend_a[p] == 0) auto_a[p] = 1'b1;
            end
            if (st_a[p]) pend_a[p] = 1;
            auto_b[p] = 1'b0;
            if (pend_b[p] > 0) begin
                pend_b[p] = pend_b[p] - 1;
                if (pend_b[p] == 0) auto_b[p] = 1'b1;
            end
            if (st_b[p]) pend_b[p] = 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {tick, phase, col/ghost/pac/in start, ghost_id, busy}
    function automatic logic [11:0] snap_a();
        return {frame_tick_a, phase_a, st_a, ghost_id_a, busy_a};
    endfunction
    function automatic logic [11:0] snap_b();
        return {frame_tick_b, phase_b, st_b, ghost_id_b, busy_b};
    endfunction

    task automatic run_until_tick(output int n, output int starts);
        n = 0;
        starts = 0;
        do begin
            @(negedge clk);
            n++;
            if (|st_a) starts++;
        end while (!frame_tick_a && n < 100);
    endtask

    typedef struct {
        logic       run;
        logic       tick;
        logic [2:0] ph;
        logic [3:0] st;
        logic [2:0] gid;
        logic       busy;
    } vec_t;
    vec_t vec [16];

    // ---------------- test sequence ----------------
    initial begin
        int n, s, ins, cols, tk;
        logic ovr;

        // Normal ghost frame, cycle by cycle from the frame_tick cycle.
        vec[0]  = '{1'b1, 1'b1, 3'd0, 4'b0000, 3'd0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 3'd1, 4'b0001, 3'd0, 1'b1};
        vec[2]  = '{1'b1, 1'b0, 3'd1, 4'b0000, 3'd0, 1'b1};
        vec[3]  = '{1'b1, 1'b0, 3'd2, 4'b0010, 3'd0, 1'b1};
        vec[4]  = '{1'b1, 1'b0, 3'd2, 4'b0000, 3'd0, 1'b1};
        vec[5]  = '{1'b1, 1'b0, 3'd3, 4'b0100, 3'd0, 1'b1};
        vec[6]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 3'd0, 1'b1};
        vec[7]  = '{1'b1, 1'b0, 3'd3, 4'b0100, 3'd1, 1'b1};
        vec[8]  = '{1'b1, 1'b0, 3'd3, 4'b0000, 3'd1, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 3'd3, 4'b0100, 3'd2, 1'b1};
        vec[10] = '{1'b1, 1'b0, 3'd3, 4'b0000, 3'd2, 1'b1};
        vec[11] = '{1'b1, 1'b0, 3'd3, 4'b0100, 3'd3, 1'b1};
        vec[12] = '{1'b1, 1'b0, 3'd3, 4'b0000, 3'd3, 1'b1};
        vec[13] = '{1'b1, 1'b0, 3'd4, 4'b1000, 3'd0, 1'b1};
        vec[14] = '{1'b1, 1'b0, 3'd4, 4'b0000, 3'd0, 1'b1};
        vec[15] = '{1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0};

        run_a = 1'b1; clear_a = 1'b0; en_a = 4'hF; man_a = 4'h0;
        run_b = 1'b1; clear_b = 1'b0; en_b = 4'hF; man_b = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a", {snap_a(), overrun_a, overrun_cnt_a, wdog_err_a}, 32'h0);
        check("reset_b", {snap_b(), overrun_b, overrun_cnt_b, wdog_err_b}, 32'h0);
        reset = 1'b1;

        // Divider: first tick 19 edges after release
        run_until_tick(n, s);
        check("first_tick_cycles", n, 19);

        // Normal frame
        for (int i = 0; i < 16; i++) begin
            run_a = vec[i].run;
            check($sformatf("frame_vec%0d", i), snap_a(),
                  {vec[i].tick, vec[i].ph, vec[i].st, vec[i].gid, vec[i].busy});
            @(negedge clk);
        end
        check("frame_overrun", {overrun_a, overrun_cnt_a}, 9'h0);

        // Ghost divider: frames 2..4 -> no ghosts, ghosts, no ghosts
        for (int f = 0; f < 3; f++) begin
            run_until_tick(n, s);
            ins = 0; cols = 0;
            for (int c = 0; c < 19; c++) begin
                @(negedge clk);
                if (ghost_start_a) ins++;
                if (col_start_a) cols++;
            end
            check($sformatf("gdiv_ghosts_f%0d", f + 2), ins, (f == 1) ? 4 : 0);
            check($sformatf("gdiv_collide_f%0d", f + 2), cols, 1);
        end

        // Overrun: col_done held low 45 cycles across two ticks
        en_a[3] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!col_start_a && n < 40);
        check("ovr_col_start_seen", col_start_a, 1);
        ins = 0; tk = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (in_start_a) ins++;
            if (frame_tick_a) tk++;
        end
        check("ovr_ticks_in_hold", tk, 2);
        check("ovr_no_frame_started", ins, 0);
        man_a[3] = 1'b1;
        @(negedge clk);
        man_a[3] = 1'b0;
        check("ovr_flag_cnt", {overrun_a, overrun_cnt_a}, {1'b1, 8'd2});
        check("ovr_phase_idle", phase_a, 0);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        check("ovr_cleared", {overrun_a, overrun_cnt_a}, 9'h0);

        // clear_err in the same cycle as a dropped tick: set wins, count 1
        n = 0;
        do begin @(negedge clk); n++; end while (!col_start_a && n < 40);
        run_until_tick(n, s);
        run_until_tick(n, s);
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        check("ovr_clear_vs_set", {overrun_a, overrun_cnt_a}, {1'b1, 8'd1});
        man_a[3] = 1'b1;
        @(negedge clk);
        man_a[3] = 1'b0;
        en_a[3] = 1'b1;
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        check("ovr_cleared2", {overrun_a, overrun_cnt_a}, 9'h0);

        // Pause: run falls mid-frame, then 3 ticks with run=0
        n = 0;
        do begin @(negedge clk); n++; end while (!in_start_a && n < 40);
        run_a = 1'b0;
        ins = 0; cols = 0; tk = 0; ovr = 1'b0; n = 0;
        while (tk < 3 && n < 80) begin
            @(negedge clk);
            n++;
            if (in_start_a) ins++;
            if (col_start_a) cols++;
            if (frame_tick_a) tk++;
            ovr = ovr | overrun_a;
        end
        check("pause_no_in_start", ins, 0);
        check("pause_frame_completes", cols, 1);
        check("pause_no_overrun", ovr, 0);
        @(negedge clk);
        run_a = 1'b1;
        run_until_tick(n, s);
        @(negedge clk);
        check("resume_latency", snap_a(), {1'b0, 3'd1, 4'b0001, 3'd0, 1'b1});

        // Reset mid-GHOST while ghost_id = 2
        n = 0;
        do begin @(negedge clk); n++; end while (!(phase_a == 3'd3 && ghost_id_a == 3'd2) && n < 80);
        check("rst_ghost2_seen", {phase_a, ghost_id_a}, {3'd3, 3'd2});
        reset = 1'b0;
        #1;
        check("rst_async_outputs", {snap_a(), overrun_a, overrun_cnt_a, wdog_err_a}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_idle", snap_a(), 12'h0);
        run_until_tick(n, s);
        check("rst_tick_cycles", n, 19);
        check("rst_no_starts", s, 0);
        @(negedge clk);
        check("rst_clean_start", snap_a(), {1'b0, 3'd1, 4'b0001, 3'd0, 1'b1});

        // Watchdog on DUT B: pac_done never comes
        en_b[1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!pac_start_b && n < 40);
        n = 0;
        do begin @(negedge clk); n++; end while (!wdog_err_b && n < 50);
        check("wdog_cycles", n, 10);
        check("wdog_to_ghost", snap_b(), {1'b0, 3'd3, 4'b0100, 3'd0, 1'b1});
        n = 0;
        do begin @(negedge clk); n++; end while (busy_b && n < 40);
        check("wdog_frame_done", busy_b, 0);
        check("wdog_sticky_ovr", {wdog_err_b, overrun_b, overrun_cnt_b}, {1'b1, 1'b1, 8'd1});
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        check("wdog_cleared", {wdog_err_b, overrun_b, overrun_cnt_b}, 10'h0);

        // clear_err in the timeout cycle: set wins
        n = 0;
        do begin @(negedge clk); n++; end while (!pac_start_b && n < 60);
        repeat (9) @(negedge clk);
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        check("wdog_clear_vs_set", {wdog_err_b, phase_b}, {1'b1, 3'd3});

        // Done in the start cycle is ignored; done outside its phase ignored
        en_b[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_start_b && n < 80);
        man_b[0] = 1'b1;
        @(negedge clk);
        man_b[0] = 1'b0;
        check("done_in_start_cycle", phase_b, 3'd1);
        man_b[0] = 1'b1;
        @(negedge clk);
        man_b[0] = 1'b0;
        check("done_later_cycle", {phase_b, pac_start_b}, {3'd2, 1'b1});
        en_b[3] = 1'b0;
        man_b = 4'b1001;
        @(negedge clk);
        man_b = 4'b0000;
        check("done_wrong_phase", phase_b, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
